// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined WIDTH x WIDTH multiplier among N_REQ requesters.
// Define MULT_ARB_SIGNED_EN for a two's-complement multiply; default is unsigned.
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*WIDTH-1:0]   req_a_i,
    input  logic [N_REQ*WIDTH-1:0]   req_b_i,
    output logic [N_REQ-1:0]         rsp_valid_o,
    output logic [2*WIDTH-1:0]       rsp_p_o,
    output logic                     busy_o
);
    localparam int PW    = 2 * WIDTH;
    localparam int TAG_W = $clog2(N_REQ);

    // Operands are extended to the full product width first, so the low PW bits
    // of the product are exact for both signed and unsigned interpretations.
    function automatic logic [PW-1:0] mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
`ifdef MULT_ARB_SIGNED_EN
        ea = {{WIDTH{a[WIDTH-1]}}, a};
        eb = {{WIDTH{b[WIDTH-1]}}, b};
`else
        ea = {{WIDTH{1'b0}}, a};
        eb = {{WIDTH{1'b0}}, b};
`endif
        return ea * eb;
    endfunction

    logic [TAG_W-1:0] rr_ptr_q;
    logic [TAG_W-1:0] rr_ptr_d;
    logic [TAG_W-1:0] win;
    logic             found;
    logic             transfer;
    logic [WIDTH-1:0] a_win;
    logic [WIDTH-1:0] b_win;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = TAG_W'(idx);
            end
        end
    end

    // The winner is always a valid requester, so a grant is itself a transfer.
    assign transfer    = found && !rst_i;
    assign req_ready_o = transfer ? ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;
    assign a_win       = req_a_i[win*WIDTH +: WIDTH];
    assign b_win       = req_b_i[win*WIDTH +: WIDTH];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            rr_ptr_d = (win == TAG_W'(N_REQ-1)) ? '0 : win + 1'b1;
        end
    end

    logic             val_q  [MUL_LAT];
    logic             val_d  [MUL_LAT];
    logic [TAG_W-1:0] tag_q  [MUL_LAT];
    logic [TAG_W-1:0] tag_d  [MUL_LAT];
    logic [PW-1:0]    data_q [MUL_LAT];
    logic [PW-1:0]    data_d [MUL_LAT];

    // Stage 0 holds the raw operand pair; the multiply sits between stage 0 and 1.
    // With a single stage the multiply moves in front of stage 0 instead.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign val_d[gi] = transfer;
                assign tag_d[gi] = win;
                if (MUL_LAT == 1) begin : g_mul
                    assign data_d[gi] = mul(a_win, b_win);
                end else begin : g_ops
                    assign data_d[gi] = {a_win, b_win};
                end
            end else begin : g_body
                assign val_d[gi] = val_q[gi-1];
                assign tag_d[gi] = tag_q[gi-1];
                if (gi == 1) begin : g_mul
                    assign data_d[gi] = mul(data_q[gi-1][PW-1:WIDTH], data_q[gi-1][WIDTH-1:0]);
                end else begin : g_fwd
                    assign data_d[gi] = data_q[gi-1];
                end
            end
        end
    endgenerate

    // Payload only advances with a valid beat, so the last stage doubles as the held rsp_p.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                val_q[s]  <= 1'b0;
                tag_q[s]  <= '0;
                data_q[s] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int s = 0; s < MUL_LAT; s++) begin
                val_q[s] <= val_d[s];
                if (val_d[s]) begin
                    tag_q[s]  <= tag_d[s];
                    data_q[s] <= data_d[s];
                end
            end
        end
    end

    assign rsp_valid_o = val_q[MUL_LAT-1] ? ({{(N_REQ-1){1'b0}}, 1'b1} << tag_q[MUL_LAT-1]) : '0;
    assign rsp_p_o     = data_q[MUL_LAT-1];

    always_comb begin
        busy_o = 1'b0;
        for (int s = 0; s < MUL_LAT; s++) begin
            busy_o = busy_o | val_q[s];
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed tables plus random traffic
// checked against a queue-based reference model of grants and due responses.
module tb_mult_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int L  = 2;
    localparam int PW = 2 * W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a = '0;
    logic [N*W-1:0]  req_b = '0;
    logic [N-1:0]    rsp_valid;
    logic [PW-1:0]   rsp_p;
    logic            busy;

    mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .MUL_LAT(L)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_p_o     (rsp_p),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic [PW-1:0] p;
        int            due;
    } ent_t;

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  ready;
        logic [N-1:0]  rv;
        logic [PW-1:0] p;
    } vec_t;

    ent_t          q[$];
    int            rr = 0;
    logic [PW-1:0] last_p = '0;
    int            cyc = 0;
    int            gwin = -1;
    int            vectors = 0;
    int            miscompares = 0;
    logic          pend [N];

    function automatic logic [PW-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_ARB_SIGNED_EN
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        return PW'(sa * sb);
`else
        return PW'(longint'(a) * longint'(b));
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: compare at the falling edge, then advance the model past the rising edge.
    task automatic tick(input bit use_tab, input logic [N-1:0] t_ready,
                        input logic [N-1:0] t_rv, input logic [PW-1:0] t_p);
        logic [N-1:0] exp_rv;
        logic [N-1:0] exp_ready;
        logic         exp_busy;
        int           win;
        @(negedge clk);
        if (rst) begin
            q.delete();
            rr     = 0;
            last_p = '0;
            gwin   = -1;
            chk("rst_ready", 64'(req_ready), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_rsp_p", 64'(rsp_p), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
        end else begin
            exp_busy = (q.size() != 0);
            exp_rv   = '0;
            if (q.size() != 0 && q[0].due == cyc) begin
                exp_rv = N'(1) << q[0].tag;
                last_p = q[0].p;
                void'(q.pop_front());
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            chk("rsp_p", 64'(rsp_p), 64'(last_p));
            chk("busy", 64'(busy), 64'(exp_busy));
            win = -1;
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req_valid[(rr + k) % N]) win = (rr + k) % N;
            end
            exp_ready = (win < 0) ? '0 : (N'(1) << win);
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            if (win >= 0) begin
                q.push_back('{tag: win, p: model_mul(req_a[win*W +: W], req_b[win*W +: W]), due: cyc + L});
                rr = (win + 1) % N;
            end
            gwin = win;
            if (use_tab) begin
                chk("tab_ready", 64'(req_ready), 64'(t_ready));
                chk("tab_rsp_valid", 64'(rsp_valid), 64'(t_rv));
                chk("tab_rsp_p", 64'(rsp_p), 64'(t_p));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0);
        rst = 1'b0;
    endtask

    vec_t tab[11];

    initial begin
        tab[0]  = '{4'b1111, 4'b0001, 4'b0000, 32'h00};
        tab[1]  = '{4'b1111, 4'b0010, 4'b0000, 32'h00};
        tab[2]  = '{4'b1111, 4'b0100, 4'b0001, 32'h10};
        tab[3]  = '{4'b1111, 4'b1000, 4'b0010, 32'h20};
        tab[4]  = '{4'b1111, 4'b0001, 4'b0100, 32'h30};
        tab[5]  = '{4'b1000, 4'b1000, 4'b1000, 32'h40};
        tab[6]  = '{4'b1001, 4'b0001, 4'b0001, 32'h10};
        tab[7]  = '{4'b1001, 4'b1000, 4'b1000, 32'h40};
        tab[8]  = '{4'b0000, 4'b0000, 4'b0001, 32'h10};
        tab[9]  = '{4'b0000, 4'b0000, 4'b1000, 32'h40};
        tab[10] = '{4'b0000, 4'b0000, 4'b0000, 32'h40};

        // Reset with random inputs toggling underneath.
        for (int i = 0; i < 3; i++) begin
            req_valid = N'($urandom);
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            tick(1'b0, '0, '0, '0);
        end
        rst = 1'b0;

        // Lone requester 2: 3 * 5.
        req_valid = 4'b0100;
        req_a[2*W +: W] = 16'h0003;
        req_b[2*W +: W] = 16'h0005;
        tick(1'b1, 4'b0100, 4'b0000, 32'h0);
        req_valid = '0;
        tick(1'b1, 4'b0000, 4'b0000, 32'h0);
        tick(1'b1, 4'b0000, 4'b0100, 32'h0000000F);
        idle(2);

        // Rotation and wrap-around from a clean pointer.
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(i + 1);
            req_b[i*W +: W] = 16'h0010;
        end
        for (int i = 0; i < 11; i++) begin
            req_valid = tab[i].valid;
            tick(1'b1, tab[i].ready, tab[i].rv, tab[i].p);
        end

        // Requester 1 alone, max operands, back to back.
        req_a[1*W +: W] = 16'hFFFF;
        req_b[1*W +: W] = 16'hFFFF;
        req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) tick(1'b0, '0, '0, '0);
        idle(L + 1);

        // Sign-sensitive product.
        req_a[0 +: W] = 16'hFFFF;
        req_b[0 +: W] = 16'h0002;
        req_valid = 4'b0001;
        tick(1'b0, '0, '0, '0);
        idle(L + 1);

        // Random traffic with held-until-granted requests, occasional drops, and a mid-burst reset.
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && gwin == i) begin
                    pend[i] = 1'b0;
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    req_a[i*W +: W] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
                    req_b[i*W +: W] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
                end
                req_valid[i] = pend[i];
            end
            rst = (c == 200 || c == 201);
            tick(1'b0, '0, '0, '0);
        end
        rst = 1'b0;
        idle(L + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
